// File: rtl/caravan_por_monitor.sv
// Digital sequencer and readback for the user-area second power-on-reset (POR2).
// Reports which POR domains are valid on GPIO pads as a 2-bit status and a
// 4-bit checkbits code. The pads are released from hi-Z only while the
// management SoC reports that GPIO configuration is done.
module caravan_por_monitor #(
   parameter int STARTUP_CYCLES  = 64,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       enable,
   input  logic       por2_vdd,
   output logic [1:0] status,
   output logic [3:0] checkbits,
   output logic [1:0] status_oeb,
   output logic [3:0] checkbits_oeb
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STARTUP = 2'd1,
      POR1    = 2'd2,
      POR2    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic en_meta_q, en_meta_d, en_sync_q, en_sync_d;
   logic por2_meta_q, por2_meta_d, por2_sync_q, por2_sync_d;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       status_q, status_d;
   logic [3:0]       checkbits_q, checkbits_d;
   logic             oeb_q, oeb_d;

   // Two-stage synchronizers for the asynchronous enable and POR2 level inputs
   always_comb begin
      en_meta_d   = enable;
      en_sync_d   = en_meta_q;
      por2_meta_d = por2_vdd;
      por2_sync_d = por2_meta_q;
   end

   // Next state, counter and registered output decode; enable loss always wins
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      status_d    = 2'b00;
      checkbits_d = 4'h0;
      oeb_d       = ~en_sync_q;
      cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

      if (!en_sync_q) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = STARTUP;
               cnt_d   = '0;
            end
            STARTUP: begin
               if (cnt_q >= START_LAST) begin
                  state_d = POR1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            POR1: begin
               if (por2_sync_q) begin
                  if (cnt_q >= DEB_LAST) begin
                     state_d = POR2;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            POR2: begin
               if (!por2_sync_q) begin
                  if (cnt_q >= DEB_LAST) begin
                     state_d = POR1;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      case (state_d)
         POR1: begin
            status_d    = 2'b01;
            checkbits_d = 4'h9;
         end
         POR2: begin
            status_d    = 2'b11;
            checkbits_d = 4'h5;
         end
         default: begin
            status_d    = 2'b00;
            checkbits_d = 4'h0;
         end
      endcase
   end

   // State, counter, synchronizer and output registers with asynchronous reset
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         en_meta_q   <= 1'b0;
         en_sync_q   <= 1'b0;
         por2_meta_q <= 1'b0;
         por2_sync_q <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         status_q    <= 2'b00;
         checkbits_q <= 4'h0;
         oeb_q       <= 1'b1;
      end else begin
         en_meta_q   <= en_meta_d;
         en_sync_q   <= en_sync_d;
         por2_meta_q <= por2_meta_d;
         por2_sync_q <= por2_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         status_q    <= status_d;
         checkbits_q <= checkbits_d;
         oeb_q       <= oeb_d;
      end
   end

   assign status        = status_q;
   assign checkbits     = checkbits_q;
   assign status_oeb    = {2{oeb_q}};
   assign checkbits_oeb = {4{oeb_q}};

endmodule

// File: tb/tb_caravan_por_monitor.sv
// Self-checking bench for caravan_por_monitor: a run-length reference model
// is compared against the pads every cycle, plus directed literal checkpoints.
module tb_caravan_por_monitor;

   localparam int S = 64;
   localparam int D = 16;

   logic       clock;
   logic       resetb;
   logic       enable;
   logic       por2_vdd;
   logic [1:0] status;
   logic [3:0] checkbits;
   logic [1:0] status_oeb;
   logic [3:0] checkbits_oeb;

   int errors = 0;
   int checks = 0;

   caravan_por_monitor #(
      .STARTUP_CYCLES (S),
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (8)
   ) dut (
      .clock        (clock),
      .resetb       (resetb),
      .enable       (enable),
      .por2_vdd     (por2_vdd),
      .status       (status),
      .checkbits    (checkbits),
      .status_oeb   (status_oeb),
      .checkbits_oeb(checkbits_oeb)
   );

   // Free-running chip clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Packed view of every pad: {status, checkbits, status_oeb, checkbits_oeb}
   logic [11:0] out_vec;
   assign out_vec = {status, checkbits, status_oeb, checkbits_oeb};

   // Reference model: synced inputs are the raw inputs delayed by two edges;
   // POR1 is valid once enable has been seen high for S+1 edges in a row;
   // POR2 flips after D consecutive synced samples disagreeing with it.
   logic m_en1, m_en2, m_p1, m_p2;
   logic m_pads_on;
   int   en_run;
   int   p_run;
   bit   m_por1;
   bit   m_por2;

   always @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         m_en1 = 0; m_en2 = 0; m_p1 = 0; m_p2 = 0;
         m_pads_on = 0;
         en_run = 0; p_run = 0; m_por1 = 0; m_por2 = 0;
      end else begin
         if (!m_en2) begin
            en_run = 0; p_run = 0; m_por1 = 0; m_por2 = 0;
         end else begin
            if (m_por1) begin
               if (m_p2 != m_por2) p_run++;
               else p_run = 0;
               if (p_run >= D) begin
                  m_por2 = !m_por2;
                  p_run  = 0;
               end
            end
            if (en_run < S + 1) en_run++;
            m_por1 = (en_run >= S + 1);
         end
         m_pads_on = m_en2;
         m_en2 = m_en1; m_en1 = enable;
         m_p2  = m_p1;  m_p1  = por2_vdd;
      end
   end

   function automatic logic [11:0] model_vec();
      logic [1:0] st;
      logic [3:0] cb;
      st = {m_por2 && m_por1, m_por1};
      cb = (m_por1 && m_por2) ? 4'h5 : (m_por1 ? 4'h9 : 4'h0);
      return {st, cb, {6{~m_pads_on}}};
   endfunction

   task automatic checkOutput(input string name, input logic [11:0] got,
                              input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge
   always @(negedge clock) begin
      checkOutput("model", out_vec, model_vec());
   end

   // Randomized enable/por2 activity with occasional enable drops and resets
   task automatic applyStimulus(input int ncycles);
      int p_left = 0;
      int e_left = 0;
      for (int i = 0; i < ncycles; i++) begin
         @(negedge clock);
         if (p_left == 0) begin
            por2_vdd = $urandom_range(0, 1);
            p_left   = $urandom_range(1, 2 * D + 4);
         end
         p_left--;
         if (e_left > 0) begin
            e_left--;
            if (e_left == 0) enable = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            enable = 1'b0;
            e_left = $urandom_range(1, 6);
         end
         if ($urandom_range(0, 999) == 0) begin
            #2 resetb = 1'b0;
            #1 checkOutput("rand_async_reset", out_vec, 12'h03F);
            @(negedge clock);
            resetb = 1'b1;
         end
      end
   endtask

   initial begin
      resetb = 1'b0; enable = 1'b0; por2_vdd = 1'b0;
      repeat (4) @(negedge clock);
      checkOutput("reset_hold", out_vec, 12'h03F);
      resetb = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("release_idle", out_vec, 12'h03F);

      enable = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("oeb_before_sync", out_vec, 12'h03F);
      @(negedge clock);
      checkOutput("oeb_on", out_vec, 12'h000);
      repeat (S - 1) @(negedge clock);
      checkOutput("startup_pending", out_vec, 12'h000);
      @(negedge clock);
      checkOutput("por1_valid", out_vec, 12'h640);

      por2_vdd = 1'b1;
      repeat (D + 1) @(negedge clock);
      checkOutput("por2_pending", out_vec, 12'h640);
      @(negedge clock);
      checkOutput("por2_valid", out_vec, 12'hD40);

      por2_vdd = 1'b0;
      repeat (D + 1) @(negedge clock);
      checkOutput("brownout_pending", out_vec, 12'hD40);
      @(negedge clock);
      checkOutput("brownout", out_vec, 12'h640);

      por2_vdd = 1'b1;
      repeat (D - 2) @(negedge clock);
      por2_vdd = 1'b0;
      repeat (2 * D) @(negedge clock);
      checkOutput("glitch_rejected", out_vec, 12'h640);

      applyStimulus(3000);

      enable = 1'b1; por2_vdd = 1'b1;
      repeat (S + D + 12) @(negedge clock);
      checkOutput("por2_reached", out_vec, 12'hD40);
      enable = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("disable_pending", out_vec, 12'hD40);
      @(negedge clock);
      checkOutput("disable_idle", out_vec, 12'h03F);

      enable = 1'b1;
      repeat (13) @(negedge clock);
      checkOutput("mid_startup", out_vec, 12'h000);
      #3 resetb = 1'b0;
      #1 checkOutput("async_reset", out_vec, 12'h03F);
      repeat (2) @(negedge clock);
      resetb = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("post_reset", out_vec, 12'h03F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
